// File: rtl/send_udp_mux.sv
// send_udp_mux: round-robin multi-channel UDP transmitter with header insertion and IP fragmentation.
// Optional per-channel packet counters (o_pkt_cnt) are built when SEND_UDP_MUX_STATS_EN is defined.
module send_udp_mux #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned MAX_FRAME = 1480
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CHANNELS-1:0]      i_req,
    input  logic [48*CHANNELS-1:0]   i_dst_mac,
    input  logic [48*CHANNELS-1:0]   i_src_mac,
    input  logic [32*CHANNELS-1:0]   i_dst_ip,
    input  logic [32*CHANNELS-1:0]   i_src_ip,
    input  logic [16*CHANNELS-1:0]   i_dst_port,
    input  logic [16*CHANNELS-1:0]   i_src_port,
    input  logic [16*CHANNELS-1:0]   i_data_len,
    input  logic [32*CHANNELS-1:0]   i_in_data,
    input  logic [CHANNELS-1:0]      i_in_vld,
    output logic [CHANNELS-1:0]      o_in_rdy,
    output logic [CHANNELS-1:0]      o_grant,
    output logic [CHANNELS-1:0]      o_done,
    output logic                     o_err,
    output logic                     o_ready,
    output logic [47:0]              o_dst_mac,
    output logic [47:0]              o_src_mac,
    output logic [31:0]              o_dst_ip,
    output logic [31:0]              o_src_ip,
    output logic                     o_ip_sync,
    input  logic                     i_ip_ready,
    output logic                     o_more_frame,
    output logic [15:0]              o_pkt_id,
    output logic [15:0]              o_frame_size,
    output logic [15:0]              o_frame_offset,
    output logic [31:0]              o_data,
    output logic                     o_vld,
`ifdef SEND_UDP_MUX_STATS_EN
    output logic [32*CHANNELS-1:0]   o_pkt_cnt,
`endif
    input  logic                     i_rdy
);
    localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [15:0] MAX_LEN = 16'd65527;
    localparam logic [15:0] FRAME_W = 16'(MAX_FRAME);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SYNC, S_WAIT, S_DONE} state_t;

    logic [47:0] dst_mac_a  [CHANNELS];
    logic [47:0] src_mac_a  [CHANNELS];
    logic [31:0] dst_ip_a   [CHANNELS];
    logic [31:0] src_ip_a   [CHANNELS];
    logic [15:0] dst_port_a [CHANNELS];
    logic [15:0] src_port_a [CHANNELS];
    logic [15:0] len_a      [CHANNELS];
    logic [31:0] in_data_a  [CHANNELS];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_unpack
        assign dst_mac_a[c]  = i_dst_mac[48*c +: 48];
        assign src_mac_a[c]  = i_src_mac[48*c +: 48];
        assign dst_ip_a[c]   = i_dst_ip[32*c +: 32];
        assign src_ip_a[c]   = i_src_ip[32*c +: 32];
        assign dst_port_a[c] = i_dst_port[16*c +: 16];
        assign src_port_a[c] = i_src_port[16*c +: 16];
        assign len_a[c]      = i_data_len[16*c +: 16];
        assign in_data_a[c]  = i_in_data[32*c +: 32];
    end

    state_t          state_q;
    logic [CW-1:0]   rr_ptr_q, gidx_q;
    logic [15:0]     pkt_id_q, udp_len_q, frame_offset_q;
    logic [15:0]     src_port_q, dst_port_q;
    logic [1:0]      udp_step_q;
    logic            bad_q, done_pend_q;
    logic [CHANNELS-1:0] grant_q, done_q;
    logic            err_q, ready_q, ip_sync_q;
    logic [47:0]     dst_mac_q, src_mac_q;
    logic [31:0]     dst_ip_q, src_ip_q;

    // First requester at or after the round-robin pointer, wrapping.
    logic [CW-1:0]   pick_idx;
    logic            pick_found;
    int unsigned     rr_j;
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        rr_j       = 0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            rr_j = 32'(rr_ptr_q) + i;
            if (rr_j >= CHANNELS) rr_j = rr_j - CHANNELS;
            if (!pick_found && i_req[CW'(rr_j)]) begin
                pick_found = 1'b1;
                pick_idx   = CW'(rr_j);
            end
        end
    end

    logic [15:0] remain, frame_size;
    logic        more_frame, stream_active;
    assign remain        = udp_len_q - frame_offset_q;
    assign more_frame    = (remain > FRAME_W);
    assign frame_size    = more_frame ? FRAME_W : remain;
    assign stream_active = (state_q == S_SYNC) || (state_q == S_WAIT);

    // Header words first, then pass the granted channel's stream through.
    always_comb begin
        o_data   = '0;
        o_vld    = 1'b0;
        o_in_rdy = '0;
        if (stream_active) begin
            case (udp_step_q)
                2'd0: begin
                    o_data = {src_port_q, dst_port_q};
                    o_vld  = 1'b1;
                end
                2'd1: begin
                    o_data = {udp_len_q, 16'h0000};
                    o_vld  = 1'b1;
                end
                default: begin
                    o_data           = in_data_a[gidx_q];
                    o_vld            = i_in_vld[gidx_q];
                    o_in_rdy[gidx_q] = i_rdy;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            rr_ptr_q       <= '0;
            gidx_q         <= '0;
            pkt_id_q       <= 16'd1;
            udp_len_q      <= '0;
            frame_offset_q <= '0;
            udp_step_q     <= '0;
            src_port_q     <= '0;
            dst_port_q     <= '0;
            bad_q          <= 1'b0;
            done_pend_q    <= 1'b0;
            grant_q        <= '0;
            done_q         <= '0;
            err_q          <= 1'b0;
            ready_q        <= 1'b1;
            ip_sync_q      <= 1'b0;
            dst_mac_q      <= '0;
            src_mac_q      <= '0;
            dst_ip_q       <= '0;
            src_ip_q       <= '0;
        end else begin
            done_q      <= '0;
            err_q       <= 1'b0;
            done_pend_q <= 1'b0;
            case (state_q)
                S_IDLE: if (pick_found) begin
                    state_q        <= S_CHECK;
                    gidx_q         <= pick_idx;
                    grant_q        <= CHANNELS'(1) << pick_idx;
                    ready_q        <= 1'b0;
                    dst_mac_q      <= dst_mac_a[pick_idx];
                    src_mac_q      <= src_mac_a[pick_idx];
                    dst_ip_q       <= dst_ip_a[pick_idx];
                    src_ip_q       <= src_ip_a[pick_idx];
                    dst_port_q     <= dst_port_a[pick_idx];
                    src_port_q     <= src_port_a[pick_idx];
                    udp_len_q      <= len_a[pick_idx] + 16'd8;
                    bad_q          <= (len_a[pick_idx] > MAX_LEN) || (len_a[pick_idx][1:0] != 2'b00);
                    frame_offset_q <= '0;
                    udp_step_q     <= '0;
                    pkt_id_q       <= pkt_id_q + 16'd1;
                end
                S_CHECK: begin
                    if (bad_q) begin
                        state_q <= S_DONE;
                        done_q  <= grant_q;
                        err_q   <= 1'b1;
                    end else begin
                        state_q   <= S_SYNC;
                        ip_sync_q <= 1'b1;
                    end
                end
                S_SYNC: if (!i_ip_ready) begin
                    state_q   <= S_WAIT;
                    ip_sync_q <= 1'b0;
                end
                S_WAIT: if (i_ip_ready) begin
                    frame_offset_q <= frame_offset_q + frame_size;
                    if (more_frame) begin
                        state_q   <= S_SYNC;
                        ip_sync_q <= 1'b1;
                    end else begin
                        state_q <= S_DONE;
                        done_q  <= grant_q;
                    end
                end
                S_DONE: begin
                    state_q  <= S_IDLE;
                    grant_q  <= '0;
                    ready_q  <= 1'b1;
                    rr_ptr_q <= (32'(gidx_q) == CHANNELS - 1) ? '0 : gidx_q + CW'(1);
                end
                default: state_q <= S_IDLE;
            endcase
            if (stream_active && i_rdy && (udp_step_q != 2'd2))
                udp_step_q <= udp_step_q + 2'd1;
        end
    end

    assign o_grant        = grant_q;
    assign o_done         = done_q;
    assign o_err          = err_q;
    assign o_ready        = ready_q;
    assign o_ip_sync      = ip_sync_q;
    assign o_dst_mac      = dst_mac_q;
    assign o_src_mac      = src_mac_q;
    assign o_dst_ip       = dst_ip_q;
    assign o_src_ip       = src_ip_q;
    assign o_pkt_id       = pkt_id_q;
    assign o_frame_offset = frame_offset_q;
    assign o_frame_size   = frame_size;
    assign o_more_frame   = more_frame;

`ifdef SEND_UDP_MUX_STATS_EN
    // Successful datagrams per channel, wrapping.
    logic [31:0] pkt_cnt_q [CHANNELS];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < CHANNELS; c++) pkt_cnt_q[c] <= '0;
        end else if (state_q == S_DONE && !bad_q) begin
            pkt_cnt_q[gidx_q] <= pkt_cnt_q[gidx_q] + 32'd1;
        end
    end
    for (genvar c = 0; c < CHANNELS; c++) begin : g_cnt
        assign o_pkt_cnt[32*c +: 32] = pkt_cnt_q[c];
    end
`endif
endmodule

// File: tb/tb_send_udp_mux.sv
// Directed self-checking bench for send_udp_mux: framing, fragmentation, arbitration, refusal, reset.
`timescale 1ns/1ps
module tb_send_udp_mux;
    localparam int unsigned CH = 4;
    localparam int unsigned MF = 1480;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic [CH-1:0]      i_req;
    logic [48*CH-1:0]   i_dst_mac, i_src_mac;
    logic [32*CH-1:0]   i_dst_ip, i_src_ip;
    logic [16*CH-1:0]   i_dst_port, i_src_port, i_data_len;
    logic [32*CH-1:0]   i_in_data;
    logic [CH-1:0]      i_in_vld, o_in_rdy, o_grant, o_done;
    logic               o_err, o_ready, o_ip_sync, i_ip_ready, o_more_frame;
    logic [47:0]        o_dst_mac, o_src_mac;
    logic [31:0]        o_dst_ip, o_src_ip, o_data;
    logic [15:0]        o_pkt_id, o_frame_size, o_frame_offset;
    logic               o_vld, i_rdy;
`ifdef SEND_UDP_MUX_STATS_EN
    logic [32*CH-1:0]   o_pkt_cnt;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;
    int tick = 0;
    logic [15:0] sport [CH];
    logic [15:0] dport [CH];
    bit ab;

    send_udp_mux #(.CHANNELS(CH), .MAX_FRAME(MF)) dut (
        .clk(clk), .rst_n(rst_n), .i_req(i_req),
        .i_dst_mac(i_dst_mac), .i_src_mac(i_src_mac),
        .i_dst_ip(i_dst_ip), .i_src_ip(i_src_ip),
        .i_dst_port(i_dst_port), .i_src_port(i_src_port),
        .i_data_len(i_data_len), .i_in_data(i_in_data), .i_in_vld(i_in_vld),
        .o_in_rdy(o_in_rdy), .o_grant(o_grant), .o_done(o_done), .o_err(o_err),
        .o_ready(o_ready), .o_dst_mac(o_dst_mac), .o_src_mac(o_src_mac),
        .o_dst_ip(o_dst_ip), .o_src_ip(o_src_ip), .o_ip_sync(o_ip_sync),
        .i_ip_ready(i_ip_ready), .o_more_frame(o_more_frame), .o_pkt_id(o_pkt_id),
        .o_frame_size(o_frame_size), .o_frame_offset(o_frame_offset),
        .o_data(o_data), .o_vld(o_vld),
`ifdef SEND_UDP_MUX_STATS_EN
        .o_pkt_cnt(o_pkt_cnt),
`endif
        .i_rdy(i_rdy)
    );

    function automatic logic [31:0] pw(input int c, input int j);
        return 32'hC000_0000 | (32'(c) << 24) | 32'(j);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_chk(input string t);
        chk({t, "_ready"},  64'(o_ready), 64'd1);
        chk({t, "_grant"},  64'(o_grant), 64'd0);
        chk({t, "_done"},   64'(o_done), 64'd0);
        chk({t, "_err"},    64'(o_err), 64'd0);
        chk({t, "_sync"},   64'(o_ip_sync), 64'd0);
        chk({t, "_vld"},    64'(o_vld), 64'd0);
        chk({t, "_inrdy"},  64'(o_in_rdy), 64'd0);
        chk({t, "_pktid"},  64'(o_pkt_id), 64'd1);
        chk({t, "_fsize"},  64'(o_frame_size), 64'd0);
        chk({t, "_foff"},   64'(o_frame_offset), 64'd0);
        chk({t, "_more"},   64'(o_more_frame), 64'd0);
        chk({t, "_dmac"},   64'(o_dst_mac), 64'd0);
        chk({t, "_sip"},    64'(o_src_ip), 64'd0);
    endtask

    task automatic start_req(input int ch, input logic [15:0] len);
        bit rdy;
        rdy = 1'b0;
        for (int c = 0; c < 20 && !rdy; c++) begin
            @(negedge clk);
            rdy = o_ready;
        end
        chk("idle_wait", 64'(rdy), 64'd1);
        i_data_len[16*ch +: 16] = len;
        i_req = '0;
        i_req[ch] = 1'b1;
    endtask

    // Acts as IP framer and payload source for one datagram on channel ch.
    task automatic serve(input int ch, input int len, input bit bp, input int stop_w,
                         input bit chk_lat, input int exp_frames, output bit aborted);
        int w, off, src, nsync, cyc, exp_size, remain;
        bit found, got, v, sf, vin, exp_more;
        logic [31:0] d, exp_d;
        w = 0; off = 0; src = 0; nsync = 0; aborted = 1'b0;
        forever begin
            found = 1'b0;
            for (cyc = 0; cyc < 50 && !found; cyc++) begin
                @(negedge clk);
                found = (o_ip_sync === 1'b1) || (o_done !== '0);
            end
            chk("sync_or_done_wait", 64'(found), 64'd1);
            if (!found || o_done !== '0) break;
            if (chk_lat && nsync == 0) chk("sync_latency", 64'(cyc), 64'd2);
            remain   = len + 8 - off;
            exp_more = (remain > int'(MF));
            exp_size = exp_more ? int'(MF) : remain;
            chk("frame_size", 64'(o_frame_size), 64'(exp_size));
            chk("frame_offset", 64'(o_frame_offset), 64'(off));
            chk("more_frame", 64'(o_more_frame), 64'(exp_more));
            chk("grant", 64'(o_grant), 64'(1 << ch));
            nsync++;
            i_ip_ready = 1'b0;
            i_rdy = 1'b0;
            @(posedge clk);
            for (int k = 0; k < exp_size / 4; k++) begin
                got = 1'b0;
                for (cyc = 0; cyc < 100 && !got; cyc++) begin
                    @(negedge clk);
                    tick++;
                    i_rdy = bp ? tick[0] : 1'b1;
                    vin = bp ? (tick % 3 != 0) : 1'b1;
                    i_in_vld = '0;
                    i_in_vld[ch] = vin;
                    i_in_data[32*ch +: 32] = pw(ch, src);
                    #1;
                    v = o_vld; d = o_data; sf = o_in_rdy[ch] & vin;
                    @(posedge clk);
                    if (i_rdy && v) begin
                        got = 1'b1;
                        exp_d = (w == 0) ? {sport[ch], dport[ch]} :
                                (w == 1) ? {16'(len + 8), 16'h0000} : pw(ch, w - 2);
                        chk($sformatf("word%0d", w), 64'(d), 64'(exp_d));
                        w++;
                    end
                    if (sf) src++;
                end
                chk("word_wait", 64'(got), 64'd1);
                if (!got) return;
                if (w == stop_w) begin
                    aborted = 1'b1;
                    return;
                end
            end
            @(negedge clk);
            i_ip_ready = 1'b1;
            i_rdy = 1'b0;
            i_in_vld = '0;
            @(posedge clk);
            off += exp_size;
        end
        chk("done", 64'(o_done), 64'(1 << ch));
        chk("done_err", 64'(o_err), 64'd0);
        chk("sync_count", 64'(nsync), 64'(exp_frames));
        chk("src_words", 64'(src), 64'(len / 4));
        chk("total_words", 64'(w), 64'(len / 4 + 2));
    endtask

    task automatic refuse(input int ch, input logic [15:0] len);
        bit seen, found;
        int cyc;
        seen = 1'b0; found = 1'b0;
        start_req(ch, len);
        for (cyc = 0; cyc < 10 && !found; cyc++) begin
            @(negedge clk);
            if (o_ip_sync === 1'b1) seen = 1'b1;
            found = (o_done !== '0);
        end
        chk("refuse_latency", 64'(cyc), 64'd2);
        chk("refuse_done", 64'(o_done), 64'(1 << ch));
        chk("refuse_err", 64'(o_err), 64'd1);
        chk("refuse_grant", 64'(o_grant), 64'(1 << ch));
        chk("refuse_nosync", 64'(seen), 64'd0);
        i_req = '0;
        @(negedge clk);
        chk("refuse_idle", 64'(o_ready), 64'd1);
        chk("refuse_err_clr", 64'(o_err), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; i_req = '0; i_in_data = '0; i_in_vld = '0;
        i_ip_ready = 1'b1; i_rdy = 1'b0; i_data_len = '0;
        for (int c = 0; c < int'(CH); c++) begin
            i_dst_mac[48*c +: 48] = 48'hD0D0_0000_0000 | 48'(c);
            i_src_mac[48*c +: 48] = 48'h5050_0000_0000 | 48'(c);
            i_dst_ip[32*c +: 32]  = 32'h0A00_0000 | 32'(c);
            i_src_ip[32*c +: 32]  = 32'hC0A8_0000 | 32'(c);
            sport[c] = 16'h1000 + 16'(c);
            dport[c] = 16'h2000 + 16'(c);
        end
        sport[0] = 16'h1234;
        dport[0] = 16'h5678;
        for (int c = 0; c < int'(CH); c++) begin
            i_src_port[16*c +: 16] = sport[c];
            i_dst_port[16*c +: 16] = dport[c];
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_chk("por");
        rst_n = 1'b1;

        // Single datagram, len 16 on ch0
        start_req(0, 16'd16);
        serve(0, 16, 1'b0, -1, 1'b1, 1, ab);
        i_req = '0;
        chk("t1_pktid", 64'(o_pkt_id), 64'd2);
        chk("t1_dmac", 64'(o_dst_mac), 64'h0000_D0D0_0000_0000);
        chk("t1_smac", 64'(o_src_mac), 64'h0000_5050_0000_0000);
        chk("t1_dip", 64'(o_dst_ip), 64'h0A00_0000);
        chk("t1_sip", 64'(o_src_ip), 64'hC0A8_0000);

        // Fragmentation with back-pressure, len 3000 on ch1
        start_req(1, 16'd3000);
        serve(1, 3000, 1'b1, -1, 1'b1, 3, ab);
        i_req = '0;
        chk("t2_dip", 64'(o_dst_ip), 64'h0A00_0001);

        // Refusals
        refuse(2, 16'd6);
        refuse(1, 16'd65532);

        // Round robin from a fresh reset
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < int'(CH); c++) i_data_len[16*c +: 16] = 16'd4;
        i_req = '1;
        for (int n = 0; n < 5; n++) begin
            serve(n % int'(CH), 4, 1'b0, -1, 1'b0, 1, ab);
            if (n == 4) i_req = '0;
        end

        // Reset in the middle of the second fragment
        start_req(0, 16'd3000);
        serve(0, 3000, 1'b1, 380, 1'b0, 3, ab);
        chk("mid_aborted", 64'(ab), 64'd1);
        @(negedge clk);
        rst_n = 1'b0; i_req = '0; i_rdy = 1'b0; i_ip_ready = 1'b1; i_in_vld = '0;
        @(negedge clk);
        rst_n = 1'b1;
        reset_chk("mid");

        // Fresh request after the reset completes normally
        start_req(3, 16'd8);
        serve(3, 8, 1'b0, -1, 1'b1, 1, ab);
        i_req = '0;
        chk("post_pktid", 64'(o_pkt_id), 64'd2);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
